// File: rtl/game_input_debouncer.sv
// rtl/game_input_debouncer.sv - push-button debouncer with press/release/auto-repeat pulses
// tick_clk is synchronized and edge-detected into sample_en; each button runs its own FSM on that rate.
module game_input_debouncer #(
  parameter int NUM_BTN      = 4,
  parameter int STABLE_TICKS = 20,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_clk,
  input  logic [NUM_BTN-1:0] btn_raw_n,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  localparam int MAX_CNT = (STABLE_TICKS > REPEAT_DELAY) ? STABLE_TICKS : REPEAT_DELAY;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CNT_SAT     = '1;
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] RPT_FIRST   = CW'(REPEAT_DELAY);
  // Reloading on every repeat keeps rcnt within REPEAT_DELAY so the counter never needs extra bits.
  localparam logic [CW-1:0] RPT_RELOAD  =
    (REPEAT_RATE < REPEAT_DELAY) ? CW'(REPEAT_DELAY - REPEAT_RATE) : '0;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  logic tick_s1_q, tick_s1_d;
  logic tick_s2_q, tick_s2_d;
  logic tick_prev_q, tick_prev_d;
  logic sample_en;

  logic [NUM_BTN-1:0] raw_s1_q, raw_s1_d;
  logic [NUM_BTN-1:0] raw_s2_q, raw_s2_d;
  logic [NUM_BTN-1:0] pressed;

  state_e        state_q [NUM_BTN];
  state_e        state_d [NUM_BTN];
  logic [CW-1:0] scnt_q  [NUM_BTN];
  logic [CW-1:0] scnt_d  [NUM_BTN];
  logic [CW-1:0] rcnt_q  [NUM_BTN];
  logic [CW-1:0] rcnt_d  [NUM_BTN];

  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] repeat_q, repeat_d;

  logic [CW-1:0] scnt_inc;
  logic [CW-1:0] rcnt_inc;

  always_comb begin
    tick_s1_d   = tick_clk;
    tick_s2_d   = tick_s1_q;
    tick_prev_d = tick_s2_q;
    raw_s1_d    = btn_raw_n;
    raw_s2_d    = raw_s1_q;
  end

  assign sample_en = tick_s2_q & ~tick_prev_q;
  assign pressed   = ~raw_s2_q;

  always_comb begin
    scnt_inc  = '0;
    rcnt_inc  = '0;
    level_d   = '0;
    press_d   = '0;
    release_d = '0;
    repeat_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      scnt_d[i]  = scnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      scnt_inc   = (scnt_q[i] == CNT_SAT) ? scnt_q[i] : scnt_q[i] + CNT_ONE;
      rcnt_inc   = (rcnt_q[i] == CNT_SAT) ? rcnt_q[i] : rcnt_q[i] + CNT_ONE;

      if (sample_en) begin
        case (state_q[i])
          RELEASED: begin
            if (pressed[i]) begin
              state_d[i] = PRESS_CHK;
              scnt_d[i]  = CNT_ONE;
            end
          end
          PRESS_CHK: begin
            if (!pressed[i]) begin
              state_d[i] = RELEASED;
              scnt_d[i]  = '0;
            end else if (scnt_q[i] == STABLE_LAST) begin
              state_d[i] = PRESSED;
              press_d[i] = 1'b1;
              scnt_d[i]  = '0;
              rcnt_d[i]  = '0;
            end else begin
              scnt_d[i] = scnt_inc;
            end
          end
          PRESSED: begin
            if (!pressed[i]) begin
              state_d[i] = RELEASE_CHK;
              scnt_d[i]  = CNT_ONE;
              rcnt_d[i]  = '0;
            end else begin
              rcnt_d[i] = rcnt_inc;
              if ((REPEAT_DELAY != 0) && (rcnt_inc == RPT_FIRST)) begin
                repeat_d[i] = 1'b1;
                rcnt_d[i]   = RPT_RELOAD;
              end
            end
          end
          RELEASE_CHK: begin
            // A press seen mid-check cancels the release and restarts the repeat delay.
            if (pressed[i]) begin
              state_d[i] = PRESSED;
              scnt_d[i]  = '0;
              rcnt_d[i]  = '0;
            end else if (scnt_q[i] == STABLE_LAST) begin
              state_d[i]   = RELEASED;
              release_d[i] = 1'b1;
              scnt_d[i]    = '0;
            end else begin
              scnt_d[i] = scnt_inc;
            end
          end
          default: begin
            state_d[i] = RELEASED;
            scnt_d[i]  = '0;
            rcnt_d[i]  = '0;
          end
        endcase
      end

      level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_CHK);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_s1_q   <= 1'b0;
      tick_s2_q   <= 1'b0;
      tick_prev_q <= 1'b0;
      raw_s1_q    <= '0;
      raw_s2_q    <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      repeat_q    <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= RELEASED;
        scnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
      end
    end else begin
      tick_s1_q   <= tick_s1_d;
      tick_s2_q   <= tick_s2_d;
      tick_prev_q <= tick_prev_d;
      raw_s1_q    <= raw_s1_d;
      raw_s2_q    <= raw_s2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        scnt_q[i]  <= scnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: tb/tb_game_input_debouncer.sv
// tb/tb_game_input_debouncer.sv - randomized bench with behavioural run-length reference model
module tb_game_input_debouncer;
  localparam int NB = 4;
  localparam int ST = 20;
  localparam int RD = 50;
  localparam int RR = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick_clk = 1'b0;
  logic [NB-1:0] btn_raw_n = '1;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

  game_input_debouncer #(
    .NUM_BTN(NB), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .tick_clk(tick_clk), .btn_raw_n(btn_raw_n),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference: a level flips after ST consecutive opposite samples; repeats count held samples.
  logic          tick_hist[$];
  logic [NB-1:0] raw_hist[$];
  logic [NB-1:0] m_lvl = '0, e_press = '0, e_rel = '0, e_rpt = '0;
  int            run[NB];
  int            hold[NB];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_hist = '{1'b0, 1'b0, 1'b0};
      raw_hist  = '{'0, '0, '0};
      m_lvl = '0; e_press = '0; e_rel = '0; e_rpt = '0;
      for (int i = 0; i < NB; i++) begin run[i] = 0; hold[i] = 0; end
    end else begin
      e_press = '0; e_rel = '0; e_rpt = '0;
      // A tick seen high two edges ago, low three edges ago, is one sample of the raw seen two ago.
      if (tick_hist[1] && !tick_hist[2]) begin
        for (int i = 0; i < NB; i++) begin
          logic p;
          p = !raw_hist[1][i];
          if (p != m_lvl[i]) begin
            run[i]++;
            if (run[i] == ST) begin
              m_lvl[i] = p; run[i] = 0; hold[i] = 0;
              if (p) e_press[i] = 1'b1; else e_rel[i] = 1'b1;
            end
          end else begin
            if (m_lvl[i]) begin
              if (run[i] != 0) hold[i] = 0;
              else begin
                hold[i]++;
                if (RD != 0 && hold[i] >= RD && ((hold[i] - RD) % RR) == 0) e_rpt[i] = 1'b1;
              end
            end
            run[i] = 0;
          end
        end
      end
      tick_hist.push_front(tick_clk);
      raw_hist.push_front(btn_raw_n);
      void'(tick_hist.pop_back());
      void'(raw_hist.pop_back());
    end
  end

  int cnt_press[NB], cnt_rel[NB], cnt_rpt[NB];

  always @(negedge clk) begin
    vectors++;
    if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_lvl, e_press, e_rel, e_rpt}) begin
      miscompares++;
      $display("FAIL outputs t=%0t got lvl/prs/rel/rpt=%h/%h/%h/%h exp=%h/%h/%h/%h", $time,
               btn_level, btn_press, btn_release, btn_repeat, m_lvl, e_press, e_rel, e_rpt);
    end
    for (int i = 0; i < NB; i++) begin
      if (btn_press[i] === 1'b1) cnt_press[i]++;
      if (btn_release[i] === 1'b1) cnt_rel[i]++;
      if (btn_repeat[i] === 1'b1) cnt_rpt[i]++;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clr_counts();
    for (int i = 0; i < NB; i++) begin cnt_press[i] = 0; cnt_rel[i] = 0; cnt_rpt[i] = 0; end
  endtask

  function automatic int total_pulses();
    int t = 0;
    for (int i = 0; i < NB; i++) t += cnt_press[i] + cnt_rel[i] + cnt_rpt[i];
    return t;
  endfunction

  // One sample: pr is the pressed pattern (1 = pressed); glitch toggles the raw lines between ticks.
  task automatic samp(input logic [NB-1:0] pr, input bit glitch);
    @(negedge clk); #1;
    btn_raw_n = ~pr;
    tick_clk  = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clk);
    #1 tick_clk = 1'b0;
    if (glitch) begin
      @(negedge clk); #1 btn_raw_n = pr;
      @(negedge clk); #1 btn_raw_n = ~pr;
    end
    repeat ($urandom_range(3, 4)) @(negedge clk);
  endtask

  task automatic samps(input int n, input logic [NB-1:0] pr);
    for (int k = 0; k < n; k++) samp(pr, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
  endtask

  logic [NB-1:0] cur;
  int            left[NB];

  initial begin
    clr_counts();
    // T1: random inputs under reset, then idle
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      tick_clk  = 1'($urandom_range(0, 1));
      btn_raw_n = NB'($urandom_range(0, 15));
    end
    @(negedge clk);
    chk("t1_outputs_in_reset", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
    #1 tick_clk = 1'b0; btn_raw_n = '1;
    @(negedge clk); #1 reset = 1'b1;
    samps(100, '0);
    chk("t1_idle_pulses", total_pulses(), 0);

    // T2: clean press on btn0
    clr_counts();
    samps(19, 4'b0001);
    chk("t2_no_press_at_19", cnt_press[0], 0);
    samp(4'b0001, 1'b0);
    chk("t2_press_at_20", cnt_press[0], 1);
    chk("t2_level0", int'(btn_level[0]), 1);
    chk("t2_others", cnt_press[1] + cnt_press[2] + cnt_press[3], 0);
    samps(20, '0);

    // T3: bounce on btn1
    clr_counts();
    samps(7, 4'b0010);
    samp(4'b0000, 1'b0);
    for (int k = 0; k < 19; k++) samp(4'b0010, 1'b1);
    chk("t3_no_press_at_27", cnt_press[1], 0);
    samp(4'b0010, 1'b0);
    chk("t3_press_at_28", cnt_press[1], 1);
    samps(20, '0);

    // T4: auto-repeat on btn2
    clr_counts();
    samps(20 + 49, 4'b0100);
    chk("t4_press", cnt_press[2], 1);
    chk("t4_no_rpt_at_49", cnt_rpt[2], 0);
    samp(4'b0100, 1'b0);
    chk("t4_rpt_at_50", cnt_rpt[2], 1);
    samps(40, 4'b0100);
    chk("t4_rpt_total", cnt_rpt[2], 5);
    samps(20, '0);

    // T5: release with bounce on btn3
    clr_counts();
    samps(20, 4'b1000);
    samps(5, '0);
    samp(4'b1000, 1'b0);
    samps(19, '0);
    chk("t5_no_release_at_19", cnt_rel[3], 0);
    chk("t5_level_held", int'(btn_level[3]), 1);
    samp(4'b0000, 1'b0);
    chk("t5_release_at_20", cnt_rel[3], 1);
    chk("t5_level_dropped", int'(btn_level[3]), 0);

    // T6: reset during PRESS_CHK and during PRESSED
    clr_counts();
    samps(10, 4'b0001);
    pulse_reset();
    samps(25, '0);
    chk("t6_no_press_after_chk_reset", cnt_press[0], 0);
    samps(20, 4'b0010);
    chk("t6_pressed", int'(btn_level[1]), 1);
    pulse_reset();
    chk("t6_level_cleared", int'(btn_level), 0);
    clr_counts();
    samps(25, '0);
    chk("t6_no_pulse_after_reset", total_pulses(), 0);

    // Random long-run stimulus with bounces, glitches and one mid-run reset
    for (int i = 0; i < NB; i++) left[i] = 0;
    cur = '0;
    for (int s = 0; s < 400; s++) begin
      for (int i = 0; i < NB; i++) begin
        if (left[i] == 0) begin
          cur[i]  = 1'($urandom_range(0, 1));
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(10, 80);
        end
        left[i]--;
      end
      samp(cur, $urandom_range(0, 7) == 0);
      if (s == 250) pulse_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
